// File: rtl/mips_bus_arbiter.sv
// mips_bus_arbiter
//   Two-requester arbiter in front of one shared memory port. Each grant
//   covers exactly one transaction. A grant ends when the memory strobes
//   MemReady, or when the memory has been silent for TIMEOUT grant cycles.
//   When both requesters ask at once, the one that was not granted last wins.
//   At least one IDLE cycle separates any two grants.
//
// Parameters
//   SIZE     address/data width
//   TIMEOUT  grant cycles allowed without MemReady before abort (2..255)
//
// Ports
//   Clock, ResetN            clock (rising edge), async active-low reset
//   Req1/2, Addr1/2,
//   WData1/2, We1/2          requester transaction inputs
//   MemReady                 shared-memory completion strobe
//   MemReq, MemAddr,
//   MemWData, MemWe          shared-memory access, muxed from the granted side
//   Select                   0 = requester 1 path, 1 = requester 2 path
//   Gnt1/2                   grant, held for the whole transaction
//   Done1/2                  completion, same cycle as MemReady
//   Err1/2                   one-cycle timeout-abort pulse (in the IDLE cycle)
//
// state  | meaning
// IDLE   | no owner; arbitrate on Req1/Req2
// GRANT1 | requester 1 owns the memory port
// GRANT2 | requester 2 owns the memory port

module mips_bus_arbiter #(
  parameter int SIZE    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic            Clock,
  input  logic            ResetN,
  input  logic            Req1,
  input  logic            Req2,
  input  logic [SIZE-1:0] Addr1,
  input  logic [SIZE-1:0] Addr2,
  input  logic [SIZE-1:0] WData1,
  input  logic [SIZE-1:0] WData2,
  input  logic            We1,
  input  logic            We2,
  input  logic            MemReady,
  output logic            MemReq,
  output logic [SIZE-1:0] MemAddr,
  output logic [SIZE-1:0] MemWData,
  output logic            MemWe,
  output logic            Select,
  output logic            Gnt1,
  output logic            Gnt2,
  output logic            Done1,
  output logic            Done2,
  output logic            Err1,
  output logic            Err2
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT1 = 2'd1,
    GRANT2 = 2'd2
  } state_t;

  // Timer value in the last grant cycle allowed before abort.
  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic       last_grant2;  // 1 = requester 2 was granted most recently
  logic [7:0] timer;

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state       <= IDLE;
      last_grant2 <= 1'b1;
      timer       <= 8'd0;
      Err1        <= 1'b0;
      Err2        <= 1'b0;
    end else begin
      Err1 <= 1'b0;
      Err2 <= 1'b0;
      case (state)
        IDLE: begin
          // MemReady is ignored here. On a tie, requester 1 wins only if
          // requester 2 held the last grant.
          if (Req1 && (!Req2 || last_grant2)) begin
            state       <= GRANT1;
            last_grant2 <= 1'b0;
            timer       <= 8'd0;
          end else if (Req2) begin
            state       <= GRANT2;
            last_grant2 <= 1'b1;
            timer       <= 8'd0;
          end
        end
        GRANT1, GRANT2: begin
          // MemReady wins over a timeout in the same cycle. last_grant2 is
          // left alone on abort, so the aborted side loses the next tie.
          if (MemReady) begin
            state <= IDLE;
          end else if (timer == TIMER_LAST) begin
            state <= IDLE;
            Err1  <= (state == GRANT1);
            Err2  <= (state == GRANT2);
          end else begin
            timer <= timer + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign Gnt1     = (state == GRANT1);
  assign Gnt2     = (state == GRANT2);
  assign MemReq   = Gnt1 | Gnt2;
  assign Select   = Gnt2;
  assign MemAddr  = Select ? Addr2  : Addr1;
  assign MemWData = Select ? WData2 : WData1;
  assign MemWe    = MemReq & (Select ? We2 : We1);
  assign Done1    = Gnt1 & MemReady;
  assign Done2    = Gnt2 & MemReady;

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Testbench for mips_bus_arbiter: directed vector table, multi-cycle corner
// sequences (timeout, MemReady on the last grant cycle, reset mid-grant) and
// randomized traffic checked against a transaction-level reference model.

module tb_mips_bus_arbiter;

  localparam int SIZE    = 32;
  localparam int TIMEOUT = 16;

  logic            Clock;
  logic            ResetN;
  logic            Req1, Req2;
  logic [SIZE-1:0] Addr1, Addr2, WData1, WData2;
  logic            We1, We2;
  logic            MemReady;
  logic            MemReq;
  logic [SIZE-1:0] MemAddr, MemWData;
  logic            MemWe, Select;
  logic            Gnt1, Gnt2, Done1, Done2, Err1, Err2;

  mips_bus_arbiter #(.SIZE(SIZE), .TIMEOUT(TIMEOUT)) dut (
    .Clock(Clock), .ResetN(ResetN),
    .Req1(Req1), .Req2(Req2),
    .Addr1(Addr1), .Addr2(Addr2),
    .WData1(WData1), .WData2(WData2),
    .We1(We1), .We2(We2),
    .MemReady(MemReady),
    .MemReq(MemReq), .MemAddr(MemAddr), .MemWData(MemWData), .MemWe(MemWe),
    .Select(Select),
    .Gnt1(Gnt1), .Gnt2(Gnt2),
    .Done1(Done1), .Done2(Done2),
    .Err1(Err1), .Err2(Err2)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [79:0] pack(logic [31:0] wd, logic [31:0] ad,
                                       logic g1, logic g2, logic d1, logic d2,
                                       logic e1, logic e2, logic we);
    return {7'b0, wd, ad, g1, g2, g1 | g2, g2, d1, d2, e1, e2, we};
  endfunction

  function automatic logic [79:0] dut_vec();
    return {7'b0, MemWData, MemAddr, Gnt1, Gnt2, MemReq, Select,
            Done1, Done2, Err1, Err2, MemWe};
  endfunction

  // Drive slot: 1 time unit after the rising edge.
  task automatic next_cycle();
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset();
    ResetN = 1'b0;
    Req1 = 1'b0; Req2 = 1'b0; MemReady = 1'b0;
    next_cycle();
    next_cycle();
    ResetN = 1'b1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        r1, r2, rdy;
    logic        g1, g2, d1, d2;
    logic [31:0] addr;
    logic        we;
  } vec_t;

  vec_t tbl[15];

  function automatic vec_t mk(logic r1, logic r2, logic rdy, logic g1, logic g2,
                              logic d1, logic d2, logic [31:0] addr, logic we);
    vec_t v;
    v.r1 = r1; v.r2 = r2; v.rdy = rdy;
    v.g1 = g1; v.g2 = g2; v.d1 = d1; v.d2 = d2;
    v.addr = addr; v.we = we;
    return v;
  endfunction

  // ---------------- reference model ----------------
  // owner: 0 none, 1/2 requester; age: 1-based cycle count within the grant;
  // last: most recent winner; err: requester whose abort shows this cycle.
  int m_owner, m_age, m_last, m_err;

  function automatic logic [79:0] model_vec();
    logic two;
    logic we;
    two = (m_owner == 2);
    we  = (m_owner != 0) && (two ? We2 : We1);
    return pack(two ? WData2 : WData1, two ? Addr2 : Addr1,
                m_owner == 1, m_owner == 2,
                (m_owner == 1) && MemReady, (m_owner == 2) && MemReady,
                m_err == 1, m_err == 2, we);
  endfunction

  task automatic model_step();
    int nerr;
    int win;
    nerr = 0;
    if (m_owner == 0) begin
      win = 0;
      if (Req1 && Req2) win = (m_last == 1) ? 2 : 1;
      else if (Req1)    win = 1;
      else if (Req2)    win = 2;
      if (win != 0) begin
        m_owner = win;
        m_last  = win;
        m_age   = 1;
      end
    end else if (MemReady) begin
      m_owner = 0;
    end else if (m_age == TIMEOUT) begin
      nerr    = m_owner;
      m_owner = 0;
    end else begin
      m_age++;
    end
    m_err = nerr;
  endtask

  initial begin
    int cnt;
    logic busy1, busy2, saw_d1, saw_d2;

    Addr1 = 32'h0000_0100; WData1 = 32'h1111_1111; We1 = 1'b0;
    Addr2 = 32'h0000_0040; WData2 = 32'hDEAD_BEEF; We2 = 1'b1;
    ResetN = 1'b0; Req1 = 1'b0; Req2 = 1'b0; MemReady = 1'b0;

    //           r1 r2 rdy g1 g2 d1 d2 addr           we
    tbl[0]  = mk(0, 0, 0,  0, 0, 0, 0, 32'h0000_0100, 0);
    tbl[1]  = mk(1, 1, 1,  0, 0, 0, 0, 32'h0000_0100, 0);
    tbl[2]  = mk(1, 1, 0,  1, 0, 0, 0, 32'h0000_0100, 0);
    tbl[3]  = mk(1, 1, 0,  1, 0, 0, 0, 32'h0000_0100, 0);
    tbl[4]  = mk(1, 1, 0,  1, 0, 0, 0, 32'h0000_0100, 0);
    tbl[5]  = mk(1, 1, 1,  1, 0, 1, 0, 32'h0000_0100, 0);
    tbl[6]  = mk(0, 1, 0,  0, 0, 0, 0, 32'h0000_0100, 0);
    tbl[7]  = mk(0, 1, 0,  0, 1, 0, 0, 32'h0000_0040, 1);
    tbl[8]  = mk(0, 1, 1,  0, 1, 0, 1, 32'h0000_0040, 1);
    tbl[9]  = mk(1, 1, 0,  0, 0, 0, 0, 32'h0000_0100, 0);
    tbl[10] = mk(1, 1, 1,  1, 0, 1, 0, 32'h0000_0100, 0);
    tbl[11] = mk(1, 1, 0,  0, 0, 0, 0, 32'h0000_0100, 0);
    tbl[12] = mk(1, 1, 1,  0, 1, 0, 1, 32'h0000_0040, 1);
    tbl[13] = mk(1, 1, 0,  0, 0, 0, 0, 32'h0000_0100, 0);
    tbl[14] = mk(1, 1, 0,  1, 0, 0, 0, 32'h0000_0100, 0);

    // Reset state, with requests and MemReady active during reset.
    #1;
    Req1 = 1'b1; Req2 = 1'b1; MemReady = 1'b1;
    @(negedge Clock);
    chk("reset_outputs", dut_vec(),
        pack(32'h1111_1111, 32'h0000_0100, 0, 0, 0, 0, 0, 0, 0));
    do_reset();

    for (int i = 0; i < 15; i++) begin
      Req1 = tbl[i].r1; Req2 = tbl[i].r2; MemReady = tbl[i].rdy;
      @(negedge Clock);
      chk($sformatf("table_row%0d", i), dut_vec(),
          pack(tbl[i].g2 ? 32'hDEAD_BEEF : 32'h1111_1111, tbl[i].addr,
               tbl[i].g1, tbl[i].g2, tbl[i].d1, tbl[i].d2, 0, 0, tbl[i].we));
      next_cycle();
    end

    // Timeout: requester 1 granted, memory silent, requester 2 pending.
    do_reset();
    Req1 = 1'b1;
    next_cycle();
    Req2 = 1'b1;
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge Clock);
      if (Done1 !== 1'b0 || Err1 !== 1'b0) break;
      if (Gnt1 !== 1'b1) break;
      cnt++;
      next_cycle();
    end
    chk("timeout_gnt1_cycles", 80'(cnt), 80'(TIMEOUT));
    chk("timeout_err_cycle", {77'b0, Err1, Gnt1, Gnt2}, 80'b100);
    next_cycle();
    @(negedge Clock);
    chk("timeout_next_grant", {77'b0, Err1, Gnt1, Gnt2}, 80'b001);
    Req1 = 1'b0;
    MemReady = 1'b1;
    next_cycle();
    Req2 = 1'b0;
    MemReady = 1'b0;

    // MemReady on the last allowed grant cycle completes normally.
    do_reset();
    Req1 = 1'b1;
    next_cycle();
    cnt = 0;
    for (int k = 1; k <= TIMEOUT; k++) begin
      MemReady = (k == TIMEOUT);
      @(negedge Clock);
      if (Gnt1 === 1'b1 && Err1 === 1'b0) cnt++;
      if (k == TIMEOUT)
        chk("last_cycle_ready_done", {78'b0, Done1, Err1}, 80'b10);
      next_cycle();
    end
    chk("last_cycle_ready_gnt_count", 80'(cnt), 80'(TIMEOUT));
    Req1 = 1'b0; MemReady = 1'b0;
    @(negedge Clock);
    chk("last_cycle_ready_no_err", {77'b0, Err1, Gnt1, Done1}, 80'b0);

    // Reset during a GRANT2 cycle.
    next_cycle();
    do_reset();
    Req2 = 1'b1;
    next_cycle();
    @(negedge Clock);
    chk("midreset_granted", {78'b0, Gnt2, Select}, 80'b11);
    #2;
    MemReady = 1'b1;
    ResetN = 1'b0;
    #1;
    chk("midreset_drop", {76'b0, Gnt2, MemReq, Done2, Err2}, 80'b0);
    next_cycle();
    ResetN = 1'b1; Req2 = 1'b0; MemReady = 1'b0;
    @(negedge Clock);
    chk("midreset_after", {75'b0, Gnt1, Gnt2, Done2, Err2, MemReq}, 80'b0);

    // Randomized traffic against the reference model.
    next_cycle();
    do_reset();
    m_owner = 0; m_age = 0; m_last = 2; m_err = 0;
    busy1 = 1'b0; busy2 = 1'b0; saw_d1 = 1'b0; saw_d2 = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (busy1 && saw_d1) begin
        if ($urandom_range(3) == 0) begin
          Addr1 = $urandom; WData1 = $urandom; We1 = 1'($urandom_range(1));
        end else begin
          Req1 = 1'b0; busy1 = 1'b0;
        end
      end else if (!busy1 && $urandom_range(2) == 0) begin
        busy1 = 1'b1; Req1 = 1'b1;
        Addr1 = $urandom; WData1 = $urandom; We1 = 1'($urandom_range(1));
      end
      if (busy2 && saw_d2) begin
        if ($urandom_range(3) == 0) begin
          Addr2 = $urandom; WData2 = $urandom; We2 = 1'($urandom_range(1));
        end else begin
          Req2 = 1'b0; busy2 = 1'b0;
        end
      end else if (!busy2 && $urandom_range(2) == 0) begin
        busy2 = 1'b1; Req2 = 1'b1;
        Addr2 = $urandom; WData2 = $urandom; We2 = 1'($urandom_range(1));
      end
      MemReady = ($urandom_range(7) == 0);
      @(negedge Clock);
      chk($sformatf("random_cycle%0d", c), dut_vec(), model_vec());
      saw_d1 = (m_owner == 1) && MemReady;
      saw_d2 = (m_owner == 2) && MemReady;
      @(posedge Clock);
      model_step();
      #1;
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
